// File: rtl/rat_uart_tx_port.sv
// RAT MCU output-port UART transmitter: decodes OUT writes into a small FIFO
// and serialises each byte as an 8N1 frame, with a status byte and a drain interrupt.
module rat_uart_tx_port #(
  parameter int         CLKS_PER_BIT   = 868,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [7:0] DATA_PORT_ID   = 8'h40,
  parameter logic [7:0] STATUS_PORT_ID = 8'h41
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  output logic [7:0] STATUS,
  output logic       TX,
  output logic       TX_INT
);

  localparam int          PTR_W     = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]  DEPTH_C   = 3'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             tx_int_q, tx_int_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [7:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic data_wr;
  logic ctrl_wr;
  logic fifo_empty;
  logic fifo_full;
  logic baud_term;
  logic pop;
  logic push;

  always_comb begin
    data_wr    = IO_STRB && (PORT_ID == DATA_PORT_ID);
    ctrl_wr    = IO_STRB && (PORT_ID == STATUS_PORT_ID) && OUT_PORT[3];
    fifo_empty = (count_q == 3'd0);
    fifo_full  = (count_q == DEPTH_C);
    baud_term  = (baud_q == BAUD_LAST);
    // The head is taken either from idle or at the end of a stop bit, so
    // back-to-back frames run with no idle bit between them.
    pop        = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_term));
    // A simultaneous pop frees the slot, so a write while full still lands.
    push       = data_wr && (!fifo_full || pop);
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      fifo_d[wr_ptr_q] = OUT_PORT;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (data_wr && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
    if (ctrl_wr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tx_int_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        if (pop) begin
          shreg_d = fifo_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_term) begin
          baud_d   = 16'd0;
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_term) begin
          baud_d  = 16'd0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_term) begin
          baud_d = 16'd0;
          if (pop) begin
            shreg_d = fifo_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d  = S_IDLE;
            tx_int_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
      end
    endcase

    // TX is registered, so it is derived from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      tx_q     <= 1'b1;
      tx_int_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      tx_int_q <= tx_int_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the count and pointers alone define validity.
  always_ff @(posedge CLK) begin
    fifo_q <= fifo_d;
  end

  assign STATUS = {1'b0, count_q, ovf_q, (state_q != S_IDLE), fifo_full, fifo_empty};
  assign TX     = tx_q;
  assign TX_INT = tx_int_q;

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Bench for rat_uart_tx_port: directed port writes, a queue/timeline model
// compared every cycle, and hand-computed literal expectations.
module tb_rat_uart_tx_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] out_port;
  logic [7:0] port_id;
  logic       io_strb;
  logic [7:0] status;
  logic       tx;
  logic       tx_int;

  int n_checks = 0;
  int n_pass   = 0;

  rat_uart_tx_port #(
    .CLKS_PER_BIT  (CPB),
    .FIFO_DEPTH    (DEPTH),
    .DATA_PORT_ID  (8'h40),
    .STATUS_PORT_ID(8'h41)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .OUT_PORT(out_port),
    .PORT_ID (port_id),
    .IO_STRB (io_strb),
    .STATUS  (status),
    .TX      (tx),
    .TX_INT  (tx_int)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending bytes plus the position inside the frame being sent.
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_active;
  bit         m_ovf;
  bit         m_int;
  bit         m_valid = 0;
  int         m_pos;

  always @(posedge clk) begin
    int sz;
    bit pop_now;
    bit wr;
    if (!rst_n) begin
      mq.delete();
      m_active = 0;
      m_ovf    = 0;
      m_int    = 0;
      m_pos    = 0;
      m_valid  = 1;
    end else begin
      sz      = mq.size();
      wr      = io_strb && (port_id == 8'h40);
      pop_now = 0;
      m_int   = 0;
      if (!m_active) begin
        if (sz > 0) pop_now = 1;
      end else if (m_pos == 10 * CPB - 1) begin
        if (sz > 0) pop_now = 1;
        else begin
          m_active = 0;
          m_int    = 1;
        end
      end else begin
        m_pos++;
      end
      if (pop_now) begin
        m_cur    = mq.pop_front();
        m_active = 1;
        m_pos    = 0;
      end
      if (wr) begin
        if (sz < DEPTH || pop_now) mq.push_back(out_port);
        else m_ovf = 1;
      end
      if (io_strb && port_id == 8'h41 && out_port[3]) m_ovf = 0;
    end
  end

  function automatic logic model_tx();
    if (!m_active) return 1'b1;
    if (m_pos < CPB) return 1'b0;
    if (m_pos < 9 * CPB) return m_cur[m_pos / CPB - 1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_status();
    int sz;
    sz = mq.size();
    return {1'b0, 3'(sz), m_ovf, m_active, (sz == DEPTH), (sz == 0)};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_tx", {7'b0, tx}, {7'b0, model_tx()});
      checkOutput("model_tx_int", {7'b0, tx_int}, {7'b0, m_int});
      checkOutput("model_status", status, model_status());
    end
  end

  task automatic applyStimulus(input logic [7:0] pid, input logic [7:0] d, input logic strb);
    port_id  = pid;
    out_port = d;
    io_strb  = strb;
    @(negedge clk);
    io_strb  = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_frame;
    bit         bit_ok;
    bit         saw_low;
    int         pulses;

    rst_n    = 1'b0;
    io_strb  = 1'b0;
    port_id  = 8'h00;
    out_port = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset values");
    checkOutput("reset_status", status, 8'h01);
    checkOutput("reset_tx", {7'b0, tx}, 8'h01);
    checkOutput("reset_tx_int", {7'b0, tx_int}, 8'h00);
    saw_low = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1;
    end
    checkOutput("idle_tx_high", {7'b0, saw_low}, 8'h00);

    $display("[TB] single byte A5");
    applyStimulus(8'h40, 8'hA5, 1'b1);
    checkOutput("write_capture_status", status, 8'h10);
    checkOutput("tx_before_pop", {7'b0, tx}, 8'h01);
    exp_frame = 10'b1_1010_0101_0;
    for (int j = 0; j < 10; j++) begin
      bit_ok = 1;
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        if (tx !== exp_frame[j]) bit_ok = 0;
      end
      checkOutput($sformatf("a5_bit%0d_held", j), {7'b0, bit_ok}, 8'h01);
    end
    @(negedge clk);
    checkOutput("a5_tx_int_pulse", {7'b0, tx_int}, 8'h01);
    checkOutput("a5_status_at_pulse", status, 8'h01);
    @(negedge clk);
    checkOutput("a5_tx_int_single", {7'b0, tx_int}, 8'h00);
    checkOutput("a5_status_after", status, 8'h01);

    $display("[TB] burst and overflow");
    for (int i = 1; i <= 6; i++) begin
      port_id  = 8'h40;
      out_port = 8'(i);
      io_strb  = 1'b1;
      @(negedge clk);
    end
    io_strb = 1'b0;
    checkOutput("burst_status_full", status, 8'h4E);
    applyStimulus(8'h41, 8'h00, 1'b1);
    checkOutput("ctrl_00_keeps_ovf", status, 8'h4E);
    pulses = 0;
    repeat (210) begin
      @(negedge clk);
      if (tx_int === 1'b1) pulses++;
    end
    checkOutput("burst_single_tx_int", 8'(pulses), 8'h01);
    checkOutput("burst_drained_status", status, 8'h09);

    $display("[TB] overflow clear");
    applyStimulus(8'h41, 8'h08, 1'b1);
    checkOutput("ovf_cleared", status, 8'h01);

    $display("[TB] address decode");
    applyStimulus(8'h3F, 8'h77, 1'b1);
    applyStimulus(8'h42, 8'h77, 1'b1);
    applyStimulus(8'h40, 8'h77, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("decode_status", status, 8'h01);
    checkOutput("decode_tx", {7'b0, tx}, 8'h01);

    $display("[TB] reset mid-frame");
    port_id = 8'h40;
    io_strb = 1'b1;
    out_port = 8'h11;
    @(negedge clk);
    out_port = 8'h22;
    @(negedge clk);
    out_port = 8'h33;
    @(negedge clk);
    io_strb = 1'b0;
    checkOutput("midframe_queued", status, 8'h24);
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midframe_reset_tx", {7'b0, tx}, 8'h01);
    checkOutput("midframe_reset_status", status, 8'h01);
    checkOutput("midframe_reset_tx_int", {7'b0, tx_int}, 8'h00);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_int === 1'b1) pulses++;
    end
    checkOutput("midframe_no_tx_int", 8'(pulses), 8'h00);
    applyStimulus(8'h40, 8'h3C, 1'b1);
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      if (tx_int === 1'b1) pulses++;
    end
    checkOutput("post_reset_tx_int", 8'(pulses), 8'h01);
    checkOutput("post_reset_status", status, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rat_uart_tx_port.md
# rat_uart_tx_port

Memory-mapped UART transmitter on the RAT MCU output port bus. It decodes `OUT` writes (`PORT_ID`, `OUT_PORT`, `IO_STRB`), buffers bytes in a small FIFO and serialises them as 8N1 frames on `TX`. It returns a status byte for the MCU's `IN_PORT` read mux and pulses `TX_INT` toward the interrupt input when the transmitter drains.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4, byte slots; legal values 2 or 4.
- `DATA_PORT_ID`, 8'h40, port ID for data writes.
- `STATUS_PORT_ID`, 8'h41, port ID for status reads and control writes.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET_N`  in  1  synchronous, active-low reset.
- `OUT_PORT`  in  8  MCU output data.
- `PORT_ID`  in  8  MCU port address.
- `IO_STRB`  in  1  MCU write strobe; one cycle per `OUT` instruction.
- `STATUS`  out  8  status byte, combinational from registers, for the `IN_PORT` mux at `STATUS_PORT_ID`.
- `TX`  out  1  serial output, registered, idle high.
- `TX_INT`  out  1  one-cycle done pulse, registered.

## Operation
- **Data write.** Occurs on an edge with `IO_STRB`=1 and `PORT_ID`=`DATA_PORT_ID`.
  - Not full: push `OUT_PORT`.
  - Full: drop the byte and set sticky `ovf`.
- **Control write.** Occurs on an edge with `IO_STRB`=1, `PORT_ID`=`STATUS_PORT_ID` and `OUT_PORT[3]`=1. It clears `ovf`. Other bits are ignored.
- **Other PORT_IDs.** No effect.
- **STATUS bits.**
  - [0] `empty`
  - [1] `full`
  - [2] `busy` (FSM not IDLE)
  - [3] `ovf`
  - [6:4] FIFO count (0..FIFO_DEPTH)
  - [7] 0
- **FIFO.** Circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle: count unchanged.
  - Push while full and pop in the same cycle: push accepted, no `ovf`.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, STOP.
  - Bit counter: `bitcnt` 0..7.
  - Baud counter: `baud` counts 0..CLKS_PER_BIT-1 and restarts at 0 on every state entry.
- **Transitions.**
  - IDLE: `TX`=1. If FIFO is not empty, pop the head into `shreg` and go to START.
  - START: `TX`=0. On `baud` terminal, go to DATA with `bitcnt`=0.
  - DATA: `TX`=`shreg[0]`. On `baud` terminal, shift right. If `bitcnt`=7, go to STOP; otherwise increment `bitcnt`.
  - STOP: `TX`=1. On `baud` terminal:
    - FIFO not empty: pop and go directly to START, with no idle bit between frames.
    - FIFO empty: go to IDLE and pulse `TX_INT` for one cycle.
- **Bit order.** LSB first. Frame = 1 start bit, 8 data bits, 1 stop bit = 10·CLKS_PER_BIT cycles.
- **Reset** (`RESET_N`=0 at an edge), including mid-frame or mid-write. After that edge:
  - FIFO empty, pointers 0, `ovf`=0.
  - FSM IDLE, `TX`=1, `TX_INT`=0, `STATUS`=8'h01.
  - A write coincident with reset is discarded.

## Timing
- **Write capture.** A strobe is sampled at edge E. The count updates after E, so `STATUS` reflects the write in cycle E+1.
- **TX start latency.** With FSM in IDLE and the FIFO empty before E, the pop happens at E+1 and `TX` goes low after edge E+1.
- **Bit timing.** Each bit is held exactly CLKS_PER_BIT cycles.
- **Start bit after stop.** The falling edge of the next start bit comes exactly 10·CLKS_PER_BIT cycles after the previous start bit's falling edge.
- **TX_INT.** Asserted for the single cycle following the final stop-bit edge.
- **busy.** Deasserts in the same cycle `TX_INT` is high.
- **Throughput.** The FIFO accepts one write per cycle. Strobe held for k cycles = k writes.
- **Back-to-back writes.** A write in the same cycle as an IDLE pop is accepted: count goes 1→1 when one was already queued.

## Test plan
- **Reset values.** `CLKS_PER_BIT`=4, reset for 2 cycles. Require `TX`=1, `TX_INT`=0, `STATUS`=8'h01. Hold idle 50 cycles: `TX` stays 1.
- **Single byte.** Write 8'hA5 to 8'h40. Require:
  - `TX` low after the next edge for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles.
  - `TX_INT` one-cycle pulse.
  - `STATUS`=8'h01 after the pulse.
- **Burst and overflow.** Write 8'h01..8'h06 on consecutive cycles. Require:
  - 8'h01 popped immediately.
  - 8'h02..8'h05 queued, 8'h06 dropped, `ovf`=1.
  - `STATUS` reads `full`, count 4, `busy` set.
  - Five contiguous frames with no idle gap and a single `TX_INT`.
- **Overflow clear.** Write 8'h08 to 8'h41. Require `ovf`=0. Writing 8'h00 to 8'h41 leaves a set `ovf` unchanged.
- **Address decode.** Strobes to 8'h3F and 8'h42 and a write to 8'h40 with `IO_STRB`=0 cause no FIFO or status change.
- **Reset mid-frame.** Assert `RESET_N`=0 during DATA bit 3 with 2 bytes queued. Require `TX`=1, `STATUS`=8'h01, no `TX_INT`, and a fresh write afterwards transmits correctly.
